// File: rtl/gcd_ctrl.sv
// Moore controller for a subtract-based GCD datapath.
// The controller sequences the operand loads and the compare/subtract loop,
// and aborts after MAX_ITER subtract steps.
module gcd_ctrl #(
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        lt,
    input  logic        gt,
    input  logic        eq,
    output logic        lda,
    output logic        ldb,
    output logic        sel1,
    output logic        sel2,
    output logic        sel_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] iter_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StCmp,
        StSubA,
        StSubB,
        StDone
    } state_t;

    localparam logic [15:0] MaxIter = 16'(MAX_ITER);

    state_t state_q;
    state_t state_d;
    logic   abort;

    // Output bundle order: {lda, ldb, sel1, sel2, sel_in, busy, done}.
    function automatic logic [6:0] decode(input state_t s);
        logic [6:0] o;
        o = 7'b0;
        case (s)
            StLoadA: o = 7'b1000110;
            StLoadB: o = 7'b0100110;
            StCmp:   o = 7'b0000010;
            StSubA:  o = 7'b1001010;
            StSubB:  o = 7'b0110010;
            StDone:  o = 7'b0000011;
            default: o = 7'b0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            StIdle:  if (start) state_d = StLoadA;
            StLoadA: state_d = StLoadB;
            StLoadB: state_d = StCmp;
            StCmp: begin
                if (eq) begin
                    state_d = StDone;
                end else if (iter_count == MaxIter) begin
                    state_d = StDone;
                    abort   = 1'b1;
                end else if (lt) begin
                    state_d = StSubB;
                end else if (gt) begin
                    state_d = StSubA;
                end else begin
                    // No flag set means a broken datapath; fail instead of looping.
                    state_d = StDone;
                    abort   = 1'b1;
                end
            end
            StSubA:  state_d = StCmp;
            StSubB:  state_d = StCmp;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lda        <= 1'b0;
            ldb        <= 1'b0;
            sel1       <= 1'b0;
            sel2       <= 1'b0;
            sel_in     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            iter_count <= 16'd0;
        end else begin
            state_q <= state_d;
            {lda, ldb, sel1, sel2, sel_in, busy, done} <= decode(state_d);
            if (state_d == StLoadA) begin
                iter_count <= 16'd0;
                err        <= 1'b0;
            end else if (state_q == StSubA || state_q == StSubB) begin
                iter_count <= iter_count + 16'd1;
            end
            if (state_q == StCmp && abort) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 Parameter: MAX_ITER, default 65535, the maximum number of subtract steps before the controller aborts with an error.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset that is synchronous and active-high.
REQ-004 Port start, input, 1, requests one GCD computation; sampled only in IDLE.
REQ-005 Port lt, input, 1, datapath flag, asserted when register A < register B.
REQ-006 Port gt, input, 1, datapath flag, asserted when register A > register B.
REQ-007 Port eq, input, 1, datapath flag, asserted when register A == register B.
REQ-008 Port lda, output, 1, load enable for register A.
REQ-009 Port ldb, output, 1, load enable for register B.
REQ-010 Port sel1, output, 1, subtractor minuend select: 0 = A, 1 = B.
REQ-011 Port sel2, output, 1, subtractor subtrahend select: 0 = A, 1 = B.
REQ-012 Port sel_in, output, 1, register bus source select: 1 = external data_in, 0 = subtractor output.
REQ-013 Port busy, output, 1, high in every state except IDLE.
REQ-014 Port done, output, 1, single-cycle completion pulse.
REQ-015 Port err, output, 1, registered flag giving the error status of the last computation.
REQ-016 Port iter_count, output, 16, number of subtract steps performed in the current or last computation.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B and DONE.
REQ-018 lda, ldb, sel1, sel2, sel_in, busy and done SHALL be decoded from the state register only (Moore), with no combinational path from inputs to outputs.
REQ-019 IDLE outputs: all 0.
- IDLE -> LOAD_A when start=1; otherwise remain in IDLE.
REQ-020 LOAD_A outputs: lda=1, sel_in=1.
- The caller SHALL present operand A on data_in during this cycle.
- LOAD_A -> LOAD_B unconditionally.
- Entering LOAD_A clears iter_count to 0 and err to 0.
REQ-021 LOAD_B outputs: ldb=1, sel_in=1.
- The caller SHALL present operand B during this cycle.
- LOAD_B -> CMP unconditionally.
REQ-022 CMP outputs: no loads, all selects 0. Transition priority:
- eq=1 -> DONE.
- Else iter_count==MAX_ITER -> DONE with err set to 1.
- Else lt=1 -> SUB_B.
- Else gt=1 -> SUB_A.
- Else (no flag asserted) -> DONE with err set to 1.
REQ-023 SUB_A outputs: lda=1, sel1=0, sel2=1, sel_in=0, so A <= A-B.
- iter_count increments by 1.
- SUB_A -> CMP.
REQ-024 SUB_B outputs: ldb=1, sel1=1, sel2=0, sel_in=0, so B <= B-A.
- iter_count increments by 1.
- SUB_B -> CMP.
REQ-025 DONE outputs: done=1, busy=1, no loads.
- DONE -> IDLE unconditionally.
- After DONE the GCD result is held in register A (and B), because no load occurs until the next LOAD_A.
REQ-026 Latency: with start sampled in cycle 0 and k subtract steps, done SHALL be high in cycle 4+2k.
REQ-027 start asserted while busy=1 SHALL be ignored; start held high in the DONE cycle SHALL NOT start a new run until it is sampled in IDLE.
REQ-028 iter_count SHALL NOT wrap; the MAX_ITER check in CMP guarantees that it stops at MAX_ITER.
REQ-029 err and iter_count SHALL hold their values from DONE through IDLE until the next LOAD_A.
REQ-030 A zero operand (flags never reach eq) SHALL terminate via the MAX_ITER abort with err=1.

Reset
REQ-031 rst=1 at a rising clk edge SHALL force IDLE and set iter_count=0, err=0, with all outputs 0 from the next cycle.
REQ-032 Reset mid-operation in any state SHALL abort the computation with no done pulse.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification (controller paired with the 16-bit datapath)
REQ-034 A=12, B=8, MAX_ITER=65535 -> sequence LOAD_A, LOAD_B, CMP, SUB_A, CMP, SUB_B, CMP, DONE; done in cycle 8; A=4; iter_count=2; err=0.
REQ-035 A=7, B=7 -> done in cycle 4; iter_count=0; A=7; err=0.
REQ-036 A=0, B=5, MAX_ITER=4 -> four SUB_B steps; done in cycle 12; err=1; iter_count=4.
REQ-037 A=65535, B=1 -> done after 65534 SUB_A steps; A=1; err=0; no premature abort.
REQ-038 Assert rst in SUB_B of a 12/8 run -> IDLE next cycle, no done pulse; a subsequent 9/6 run returns A=3 with iter_count=2.
REQ-039 start held high continuously -> back-to-back runs with one IDLE cycle between DONE and the next LOAD_A; start pulses during busy are ignored.
